// File: rtl/gpio_bank.sv
// GPIO bank on the picosoc iomem bus: direction control, atomic set/clear/toggle,
// synchronised inputs and rising/falling edge interrupt capture.
module gpio_bank #(
  parameter int unsigned         NUM_PINS    = 8,
  parameter logic [31:0]         BASE_ADDR   = 32'h0300_0000,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [NUM_PINS-1:0] RESET_OUT   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);

  localparam int unsigned W = NUM_PINS;

  localparam logic [5:0] REG_OUT     = 6'h00;
  localparam logic [5:0] REG_DIR     = 6'h01;
  localparam logic [5:0] REG_IN      = 6'h02;
  localparam logic [5:0] REG_SET     = 6'h03;
  localparam logic [5:0] REG_CLR     = 6'h04;
  localparam logic [5:0] REG_TGL     = 6'h05;
  localparam logic [5:0] REG_RISE_EN = 6'h06;
  localparam logic [5:0] REG_FALL_EN = 6'h07;
  localparam logic [5:0] REG_STATUS  = 6'h08;

  logic [W-1:0] out_q, out_d;
  logic [W-1:0] dir_q, dir_d;
  logic [W-1:0] rise_en_q, rise_en_d;
  logic [W-1:0] fall_en_q, fall_en_d;
  logic [W-1:0] status_q, status_d;
  logic [W-1:0] prev_q, prev_d;
  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic         ready_q, ready_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         irq_q, irq_d;

  logic [W-1:0] in_c, rise_c, fall_c, wmask_c, wbits_c, w1c_c;
  logic [31:0]  bmask_c, rd_val_c;
  logic [5:0]   word_c;
  logic         hit_c, wr_c;
  logic         unused_ok;

  assign unused_ok = ^{iomem_addr[1:0], iomem_wdata};

  // Decode, register writes, edge capture and read mux
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_c     = '0;
    rd_val_c  = 32'h0;

    sync_d[0] = gpio_in;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    in_c   = sync_q[SYNC_STAGES-1];
    prev_d = in_c;
    rise_c = in_c & ~prev_q;
    fall_c = ~in_c & prev_q;

    // ready_q blocks re-decode of the request being acknowledged
    hit_c   = iomem_valid && !ready_q && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    wr_c    = hit_c && (iomem_wstrb != 4'b0000);
    word_c  = iomem_addr[7:2];
    bmask_c = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
               {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    wmask_c = W'(bmask_c);
    wbits_c = W'(iomem_wdata & bmask_c);

    if (wr_c) begin
      case (word_c)
        REG_OUT:     out_d     = (out_q & ~wmask_c) | wbits_c;
        REG_DIR:     dir_d     = (dir_q & ~wmask_c) | wbits_c;
        REG_SET:     out_d     = out_q | wbits_c;
        REG_CLR:     out_d     = out_q & ~wbits_c;
        REG_TGL:     out_d     = out_q ^ wbits_c;
        REG_RISE_EN: rise_en_d = (rise_en_q & ~wmask_c) | wbits_c;
        REG_FALL_EN: fall_en_d = (fall_en_q & ~wmask_c) | wbits_c;
        REG_STATUS:  w1c_c     = wbits_c;
        default:     ;
      endcase
    end

    // A new edge wins over a simultaneous W1C
    status_d = (status_q & ~w1c_c) | (rise_c & rise_en_q) | (fall_c & fall_en_q);
    irq_d    = |(status_q & (rise_en_q | fall_en_q));

    case (word_c)
      REG_OUT:     rd_val_c = 32'(out_q);
      REG_DIR:     rd_val_c = 32'(dir_q);
      REG_IN:      rd_val_c = 32'(in_c);
      REG_RISE_EN: rd_val_c = 32'(rise_en_q);
      REG_FALL_EN: rd_val_c = 32'(fall_en_q);
      REG_STATUS:  rd_val_c = 32'(status_q);
      default:     rd_val_c = 32'h0;
    endcase

    ready_d = hit_c;
    rdata_d = hit_c ? rd_val_c : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= RESET_OUT;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      sync_q    <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'h0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= prev_d;
      sync_q    <= sync_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign gpio_out    = out_q;
  assign gpio_oe     = dir_q;
  assign irq         = irq_q;
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: table of register accesses plus hand-written
// sequences for synchroniser latency, edge interrupts, set-vs-W1C and reset.
module tb_gpio_bank;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  gpio_bank #(
    .NUM_PINS(8), .BASE_ADDR(BASE), .SYNC_STAGES(2), .RESET_OUT(8'h00)
  ) dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  off;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One bus access, entered and left at posedge+1; checks one-cycle ready
  task automatic access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    tick();
    chk("ready_rise", 32'(iomem_ready), 32'd1);
    rd = iomem_rdata;
    iomem_valid = 1'b0; iomem_wstrb = 4'b0000;
    tick();
    chk("ready_width", 32'(iomem_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int acks;

    //            off    strb     wdata          exp_rd  out    oe
    vecs[0]  = '{8'h00, 4'b0000, 32'h0,         32'h00, 8'h00, 8'h00};
    vecs[1]  = '{8'h04, 4'b0000, 32'h0,         32'h00, 8'h00, 8'h00};
    vecs[2]  = '{8'h20, 4'b0000, 32'h0,         32'h00, 8'h00, 8'h00};
    vecs[3]  = '{8'h00, 4'b0001, 32'h0000_00A5, 32'h00, 8'hA5, 8'h00};
    vecs[4]  = '{8'h0C, 4'b1111, 32'h0000_000A, 32'h00, 8'hAF, 8'h00};
    vecs[5]  = '{8'h10, 4'b1111, 32'h0000_0081, 32'h00, 8'h2E, 8'h00};
    vecs[6]  = '{8'h14, 4'b1111, 32'h0000_00FF, 32'h00, 8'hD1, 8'h00};
    vecs[7]  = '{8'h00, 4'b0010, 32'h0000_FF00, 32'h00, 8'hD1, 8'h00};
    vecs[8]  = '{8'h00, 4'b0000, 32'h0,         32'hD1, 8'hD1, 8'h00};
    vecs[9]  = '{8'h0C, 4'b0000, 32'h0,         32'h00, 8'hD1, 8'h00};
    vecs[10] = '{8'h04, 4'b1111, 32'h0000_000F, 32'h00, 8'hD1, 8'h0F};
    vecs[11] = '{8'h04, 4'b0000, 32'h0,         32'h0F, 8'hD1, 8'h0F};
    vecs[12] = '{8'h3C, 4'b1111, 32'hFFFF_FFFF, 32'h00, 8'hD1, 8'h0F};
    vecs[13] = '{8'h00, 4'b1111, 32'hFFFF_FF5A, 32'h00, 8'h5A, 8'h0F};
    vecs[14] = '{8'h00, 4'b0000, 32'h0,         32'h5A, 8'h5A, 8'h0F};

    reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'b0000;
    iomem_addr = 32'h0; iomem_wdata = 32'h0; gpio_in = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_out", 32'(gpio_out), 32'h00);
    chk("rst_oe", 32'(gpio_oe), 32'h00);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ready", 32'(iomem_ready), 32'h0);
    chk("rst_rdata", iomem_rdata, 32'h0);

    foreach (vecs[i]) begin
      access(BASE + 32'(vecs[i].off), vecs[i].strb, vecs[i].wdata, rd);
      if (vecs[i].strb == 4'b0000) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
    end

    // Synchronised input
    gpio_in = 8'h3C;
    repeat (3) tick();
    access(BASE + 32'h08, 4'b0000, 32'h0, rd);
    chk("in_read", rd, 32'h3C);

    // Out-of-window address never acknowledged, write has no effect
    iomem_valid = 1'b1; iomem_addr = BASE + 32'h100; iomem_wstrb = 4'b1111; iomem_wdata = 32'h0;
    acks = 0;
    repeat (6) begin
      tick();
      if (iomem_ready) acks++;
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'b0000;
    tick();
    chk("nomatch_ack", 32'(acks), 32'd0);
    chk("nomatch_out", 32'(gpio_out), 32'h5A);

    // Edge interrupts: rise on pin0, fall on pin1
    access(BASE + 32'h18, 4'b1111, 32'h01, rd);
    access(BASE + 32'h1C, 4'b1111, 32'h02, rd);
    gpio_in = 8'h3E;
    repeat (5) tick();
    chk("irq_idle", 32'(irq), 32'h0);
    gpio_in = 8'h3D;
    tick(); tick(); tick();
    chk("irq_edge3", 32'(irq), 32'h0);
    tick();
    chk("irq_edge4", 32'(irq), 32'h1);
    tick();
    gpio_in = 8'h3E;
    repeat (4) tick();
    access(BASE + 32'h20, 4'b0000, 32'h0, rd);
    chk("status_both", rd, 32'h03);
    access(BASE + 32'h20, 4'b0010, 32'h0000_0101, rd);
    access(BASE + 32'h20, 4'b0000, 32'h0, rd);
    chk("status_strb_gate", rd, 32'h03);
    access(BASE + 32'h20, 4'b1111, 32'h01, rd);
    access(BASE + 32'h20, 4'b0000, 32'h0, rd);
    chk("status_w1c0", rd, 32'h02);
    chk("irq_still", 32'(irq), 32'h1);
    access(BASE + 32'h20, 4'b1111, 32'h02, rd);
    chk("irq_cleared", 32'(irq), 32'h0);

    // W1C on the same edge that a new rise sets bit0: set wins
    gpio_in = 8'h3F;
    tick(); tick();
    access(BASE + 32'h20, 4'b1111, 32'h01, rd);
    access(BASE + 32'h20, 4'b0000, 32'h0, rd);
    chk("set_wins", rd, 32'h01);
    chk("set_wins_irq", 32'(irq), 32'h1);

    // Reset while a write is pending
    iomem_valid = 1'b1; iomem_addr = BASE; iomem_wstrb = 4'b1111; iomem_wdata = 32'h77;
    reset = 1'b1;
    tick();
    chk("rstmid_ready", 32'(iomem_ready), 32'h0);
    chk("rstmid_out", 32'(gpio_out), 32'h00);
    chk("rstmid_oe", 32'(gpio_oe), 32'h00);
    chk("rstmid_irq", 32'(irq), 32'h0);
    iomem_valid = 1'b0; iomem_wstrb = 4'b0000;
    tick();
    reset = 1'b0;
    tick();
    chk("rstmid_hold", 32'(gpio_out), 32'h00);
    access(BASE, 4'b1111, 32'h77, rd);
    chk("reissue_out", 32'(gpio_out), 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
